// File: rtl/flp_pkg.sv
// Shared types and widths for the integer to single-precision float converter.
package flp_pkg;
  localparam int FLP_BIAS = 127;
  localparam int MAG_W    = 25;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;

  typedef enum logic [2:0] {
    IDLE,
    DETECT,
    SHIFT,
    PACK,
    DONE
  } flp_state_t;
endpackage

// File: rtl/lod25.sv
// Leading-one detector: pos 0 means bit 24 set, pos 24 means only bit 0 set.
module lod25
  import flp_pkg::*;
(
  input  logic [MAG_W-1:0] mag,
  output logic [4:0]       pos,
  output logic             zero
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    pos = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag[i]) pos = 5'(MAG_W - 1 - i);
    end
  end

  assign zero = ~|mag;

endmodule

// File: rtl/int_to_flp_seq.sv
// Sequential sign/magnitude integer to IEEE-754 single converter (normalise by stepped shifts).
// Define ROUND_NEAREST_EN for round-to-nearest-even in PACK; otherwise the round bit is truncated.
module int_to_flp_seq
  import flp_pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [MAG_W-1:0] in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_flp,
  output logic             zero_flag,
  output logic             busy
);

  localparam int EM_W = EXP_W + MAN_W;
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  flp_state_t       state, state_nxt;
  logic             sign_r;
  logic [MAG_W-1:0] mag_r;
  logic [4:0]       p_r;
  logic [4:0]       rem_r;
  logic             zero_r;
  logic [4:0]       lod_pos;
  logic             lod_zero;
  logic [4:0]       step_amt;
  logic [EM_W-1:0]  em_trunc;
  logic [EM_W-1:0]  em_final;

  function automatic logic [EXP_W-1:0] flp_exp(input logic [4:0] p);
    return EXP_W'(FLP_BIAS + MAG_W - 1 - int'(p));
  endfunction

`ifdef ROUND_NEAREST_EN
  // Adding into the packed {exp,man} lets a mantissa carry-out bump the exponent.
  function automatic logic [EM_W-1:0] round_ne(input logic [EM_W-1:0] em, input logic rnd);
    return em + EM_W'(rnd & em[0]);
  endfunction
`endif

  lod25 u_lod (
    .mag  (mag_r),
    .pos  (lod_pos),
    .zero (lod_zero)
  );

  assign step_amt = (rem_r < STEP) ? rem_r : STEP;
  assign em_trunc = {flp_exp(p_r), mag_r[MAN_W:1]};

`ifdef ROUND_NEAREST_EN
  assign em_final = round_ne(em_trunc, mag_r[0]);
`else
  assign em_final = em_trunc;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = DETECT;
      DETECT:  state_nxt = (lod_zero || lod_pos == 5'd0) ? PACK : SHIFT;
      SHIFT:   if (rem_r == step_amt) state_nxt = PACK;
      PACK:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r    <= 1'b0;
      mag_r     <= '0;
      p_r       <= '0;
      rem_r     <= '0;
      zero_r    <= 1'b0;
      out_flp   <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= in_sign;
            mag_r  <= in_mag;
          end
        end
        DETECT: begin
          p_r    <= lod_pos;
          rem_r  <= lod_pos;
          zero_r <= lod_zero;
        end
        SHIFT: begin
          mag_r <= mag_r << step_amt;
          rem_r <= rem_r - step_amt;
        end
        PACK: begin
          if (zero_r) begin
            out_flp   <= {sign_r, 31'b0};
            zero_flag <= 1'b1;
          end else begin
            out_flp   <= {sign_r, em_final};
            zero_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_flp_seq.sv
// Randomised and directed self-checking bench for int_to_flp_seq (SHIFT_STEP = 8).
module tb_int_to_flp_seq;

  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [24:0] in_mag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_flp;
  logic        zero_flag;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  int_to_flp_seq #(.SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flp   (out_flp),
    .zero_flag (zero_flag),
    .busy      (busy)
  );

  // Reference: value = 2^e * (1 + frac/2^e), mantissa is frac aligned to 23 bits.
  function automatic logic [31:0] ref_flp(input logic s, input logic [24:0] m);
    int unsigned v, frac, man;
    int e;
    v = m;
    if (v == 0) return {s, 31'b0};
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    frac = v - (32'd1 << e);
    if (e <= 23) begin
      man = frac << (23 - e);
    end else begin
      man = frac >> 1;
`ifdef ROUND_NEAREST_EN
      if ((frac & 1) != 0 && (man & 1) != 0) man++;
      if (man == (32'd1 << 23)) begin
        man = 0;
        e++;
      end
`endif
    end
    return {s, 8'(127 + e), 23'(man)};
  endfunction

  function automatic int ref_lat(input logic [24:0] m);
    int unsigned v;
    int e, p;
    v = m;
    if (v == 0) return 3;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    p = 24 - e;
    return 3 + (p + STEP - 1) / STEP;
  endfunction

  // Stimulus driver only; called #1 after a rising edge with out_ready low.
  task automatic run_op(input logic s, input logic [24:0] m, output int lat,
                        output logic [31:0] flp, output logic zf, output bit tmo);
    int w;
    tmo = 0;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) tmo = 1;
    in_sign = s; in_mag = m; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) tmo = 1;
    flp = out_flp;
    zf = zero_flag;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, zero_flag} !== 4'b1000 || out_flp !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: rdy/vld/busy/zf=%b flp=%h, want 1000 flp=00000000",
               {in_ready, out_valid, busy, zero_flag}, out_flp);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic        s_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [24:0] m_t [6] = '{25'h1000000, 25'h1, 25'h1FFFFFF, 25'h1000001, 25'h0, 25'h5};
    logic [31:0] f_t [6];
    logic        z_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          l_t [6] = '{3, 6, 3, 3, 3, 6};
    int lat;
    logic [31:0] flp;
    logic zf;
    bit tmo;
    f_t[0] = 32'h4B800000;
    f_t[1] = 32'h3F800000;
`ifdef ROUND_NEAREST_EN
    f_t[2] = 32'h4C000000;
`else
    f_t[2] = 32'h4BFFFFFF;
`endif
    f_t[3] = 32'h4B800000;
    f_t[4] = 32'h80000000;
    f_t[5] = 32'hC0A00000;
    for (int i = 0; i < 6; i++) begin
      run_op(s_t[i], m_t[i], lat, flp, zf, tmo);
      vectors++;
      if (tmo || flp !== f_t[i]) begin
        miscompares++;
        $display("FAIL directed_flp[%0d] mag=%h: got %h (tmo=%0d), want %h", i, m_t[i], flp, tmo, f_t[i]);
      end
      vectors++;
      if (zf !== z_t[i]) begin
        miscompares++;
        $display("FAIL directed_zero[%0d]: got %b, want %b", i, zf, z_t[i]);
      end
      vectors++;
      if (lat != l_t[i]) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, l_t[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat, w;
    logic [31:0] flp;
    logic zf, s;
    logic [24:0] m;
    bit tmo;
    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(1, 25);
      m = 25'($urandom() & ((32'd1 << w) - 1));
      if (i % 10 == 3) m = '0;
      s = 1'($urandom_range(0, 1));
      run_op(s, m, lat, flp, zf, tmo);
      vectors++;
      if (tmo || flp !== ref_flp(s, m) || zf !== (m == 0)) begin
        miscompares++;
        $display("FAIL random_result s=%b mag=%h: got %h zf=%b, want %h zf=%b",
                 s, m, flp, zf, ref_flp(s, m), (m == 0));
      end
      vectors++;
      if (lat != ref_lat(m)) begin
        miscompares++;
        $display("FAIL random_latency mag=%h: got %0d, want %0d", m, lat, ref_lat(m));
      end
    end
  endtask

  task automatic test_hold();
    int lat, unstable;
    logic [31:0] held;
    in_sign = 1'b0; in_mag = 25'h1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_sign = 1'b1; in_mag = 25'h1FFFFFF;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    vectors++;
    if (!out_valid || out_flp !== 32'h3F800000) begin
      miscompares++;
      $display("FAIL hold_result: vld=%b flp=%h, want 1 3f800000", out_valid, out_flp);
    end
    held = out_flp;
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!out_valid || out_flp !== held || in_ready) unstable++;
    end
    vectors++;
    if (unstable != 0) begin
      miscompares++;
      $display("FAIL hold_stable: %0d unstable cycles, want 0", unstable);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    // out_ready outside DONE must not matter.
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_out_ready: busy=%b vld=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int want;
    in_sign = 1'b0; in_mag = 25'h100; in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (in_ready) acc.push_back(n);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    want = 1 + ref_lat(25'h100);
    vectors++;
    if (acc.size() < 3 || acc[1] - acc[0] != want || acc[2] - acc[1] != want) begin
      miscompares++;
      $display("FAIL issue_interval: accepts=%0d first gaps %0d %0d, want %0d", acc.size(),
               (acc.size() > 1) ? acc[1] - acc[0] : -1, (acc.size() > 2) ? acc[2] - acc[1] : -1, want);
    end
    for (int w = 0; w < 20 && !in_ready; w++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int lat, seen;
    logic [31:0] flp;
    logic zf;
    bit tmo;
    in_sign = 1'b0; in_mag = 25'h1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, zero_flag} !== 4'b1000 || out_flp !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset_mid_shift: rdy/vld/busy/zf=%b flp=%h, want 1000 00000000",
               {in_ready, out_valid, busy, zero_flag}, out_flp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL no_result_after_reset: %0d active cycles, want 0", seen);
    end
    run_op(1'b1, 25'h5, lat, flp, zf, tmo);
    vectors++;
    if (tmo || flp !== 32'hC0A00000 || zf !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_convert: got %h zf=%b, want c0a00000 zf=0", flp, zf);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_to_flp_seq.md
INT_TO_FLP_SEQ -- requirements
Module: int_to_flp_seq

Interface
REQ-001 SHALL have parameter SHIFT_STEP, default 8, max left-shift bits per SHIFT cycle; legal range 1..24.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request carries valid operand.
REQ-005 SHALL have port in_ready  output  1  block can accept operand.
REQ-006 SHALL have port in_sign  input  1  operand sign.
REQ-007 SHALL have port in_mag  input  25  unsigned operand magnitude.
REQ-008 SHALL have port out_valid  output  1  out_flp holds a result.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port out_flp  output  32  IEEE-754 single-precision result.
REQ-011 SHALL have port zero_flag  output  1  result is signed zero.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, DETECT, SHIFT, PACK, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; accept on in_valid&in_ready, capture in_sign/in_mag, go DETECT.
REQ-015 DETECT SHALL register leading-one position p (0 = bit 24 set, 24 = only bit 0 set) and zero indication; go PACK if p==0 or zero, else SHIFT.
REQ-016 SHIFT SHALL left-shift the captured magnitude by min(remaining, SHIFT_STEP) per cycle and go PACK when remaining reaches 0; SHIFT lasts k=ceil(p/SHIFT_STEP) cycles.
REQ-017 PACK SHALL form exponent 127+24-p, mantissa = shifted bits [23:1], round bit = shifted bit 0, register out_flp/zero_flag, go DONE.
REQ-018 Zero magnitude SHALL produce out_flp={in_sign,31'b0}, zero_flag=1; nonzero SHALL give zero_flag=0.
REQ-019 DONE SHALL hold out_valid=1 and out_flp stable until out_ready=1, then go IDLE; out_valid SHALL be 0 in all other states.
REQ-020 Latency SHALL be 3+k rising edges from the accepting edge to out_valid=1.
REQ-021 out_ready outside DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored (no capture).
REQ-022 No back-to-back accept: minimum issue interval SHALL be 4+k cycles.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, in_ready=1, out_valid=0, out_flp=0, zero_flag=0, busy=0, internal registers 0.
REQ-024 Reset asserted in any state, including mid-SHIFT or DONE, SHALL discard the in-flight operand; no result SHALL be emitted after release.

Configuration
REQ-025 Macro ROUND_NEAREST_EN defined: PACK SHALL round-to-nearest-even (round bit 1 and mantissa LSB 1 -> increment; mantissa carry-out -> mantissa 0, exponent+1).
REQ-026 Macro ROUND_NEAREST_EN undefined: PACK SHALL truncate (round bit discarded); all other behaviour identical.

Structure
REQ-027 Shared package flp_pkg SHALL hold the state enum, FLP_BIAS=127, MAG_W=25, EXP_W=8, MAN_W=23.
REQ-028 Leading-one detection SHALL be a sub-module lod25 (25-bit in, 5-bit position, zero flag), instantiated once, outputs registered in DETECT.

Verification
REQ-029 in_mag=25'h1000000, sign 0 -> out_flp=32'h4B800000, out_valid 3 edges after accept.
REQ-030 in_mag=1, sign 0, SHIFT_STEP=8 -> out_flp=32'h3F800000, out_valid 6 edges after accept.
REQ-031 in_mag=25'h1FFFFFF -> 32'h4C000000 with ROUND_NEAREST_EN, 32'h4BFFFFFF without; in_mag=25'h1000001 -> 32'h4B800000 in both.
REQ-032 in_mag=0, sign 1 -> out_flp=32'h80000000, zero_flag=1; in_mag=5, sign 1 -> 32'hC0A00000, zero_flag=0.
REQ-033 out_ready held 0 for 10 cycles in DONE -> out_valid and out_flp stable; in_valid pulses during busy not captured.
REQ-034 rst_n low mid-SHIFT -> immediate IDLE with all outputs 0; next operand converts correctly.
